// File: rtl/seg_scan_driver_pkg.sv
// seg_scan_driver_pkg: active-low glyph and anode constants for the scan driver
package seg_scan_driver_pkg;
   localparam logic [6:0] SEG_0    = 7'h40;
   localparam logic [6:0] SEG_1    = 7'h79;
   localparam logic [6:0] SEG_2    = 7'h24;
   localparam logic [6:0] SEG_3    = 7'h30;
   localparam logic [6:0] SEG_4    = 7'h19;
   localparam logic [6:0] SEG_5    = 7'h12;
   localparam logic [6:0] SEG_6    = 7'h02;
   localparam logic [6:0] SEG_7    = 7'h78;
   localparam logic [6:0] SEG_8    = 7'h00;
   localparam logic [6:0] SEG_9    = 7'h10;
   localparam logic [6:0] SEG_DASH = 7'h3F;
   localparam logic [6:0] SEG_OFF  = 7'h7F;
   localparam logic [3:0] ANODE_OFF = 4'hF;
endpackage

// File: rtl/seg_glyph_rom.sv
// seg_glyph_rom: 4-bit value to active-low {g..a} pattern; 10..15 render as a dash
module seg_glyph_rom
   import seg_scan_driver_pkg::*;
(
   input  logic [3:0] val,
   output logic [6:0] glyph
);
   always_comb begin
      case (val)
         4'd0:    glyph = SEG_0;
         4'd1:    glyph = SEG_1;
         4'd2:    glyph = SEG_2;
         4'd3:    glyph = SEG_3;
         4'd4:    glyph = SEG_4;
         4'd5:    glyph = SEG_5;
         4'd6:    glyph = SEG_6;
         4'd7:    glyph = SEG_7;
         4'd8:    glyph = SEG_8;
         4'd9:    glyph = SEG_9;
         default: glyph = SEG_DASH;
      endcase
   end
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 4-digit common-anode scanner with per-slot blanking and frame-synchronous input snapshot
module seg_scan_driver
   import seg_scan_driver_pkg::*;
#(
   parameter int CLK_HZ    = 100_000_000,
   parameter int FRAME_HZ  = 1000,
   parameter int BLANK_CYC = 500
) (
   input  logic        clk_fpga,
   input  logic        reset_n,
   input  logic [15:0] digits,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  digit_en,
   input  logic        lz_blank,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  anode_sel,
   output logic        frame_tick
);
   localparam int DIG_CYC = CLK_HZ / (FRAME_HZ * 4);
   localparam int CW = $clog2(DIG_CYC);
   localparam logic [CW-1:0] SLOT_LAST  = CW'(DIG_CYC - 1);
   localparam logic [CW-1:0] SLOT_BLANK = CW'(BLANK_CYC);

   logic [CW-1:0] slot_q, slot_d;
   logic [1:0]    idx_q, idx_d;
   logic [15:0]   dig_sh_q, dig_sh_d;
   logic [3:0]    dp_sh_q, dp_sh_d;
   logic [3:0]    en_sh_q, en_sh_d;
   logic          lz_sh_q, lz_sh_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;
   logic [3:0]    an_q, an_d;
   logic          last_slot, snap, sup3, sup2, sup1, show;
   logic [3:0]    vis, cur;
   logic [6:0]    glyph;

   seg_glyph_rom u_rom (.val(cur), .glyph(glyph));

   always_comb begin
      last_slot = slot_q == SLOT_LAST;
      snap      = last_slot && idx_q == 2'd3;
      slot_d    = last_slot ? '0 : slot_q + 1'b1;
      idx_d     = last_slot ? idx_q + 2'd1 : idx_q;
      dig_sh_d  = snap ? digits : dig_sh_q;
      dp_sh_d   = snap ? dp_in : dp_sh_q;
      en_sh_d   = snap ? digit_en : en_sh_q;
      lz_sh_d   = snap ? lz_blank : lz_sh_q;
      // suppression ripples down from the leftmost digit; digit0 always shows
      sup3      = lz_sh_q && dig_sh_q[15:12] == 4'd0;
      sup2      = sup3 && dig_sh_q[11:8] == 4'd0;
      sup1      = sup2 && dig_sh_q[7:4] == 4'd0;
      vis       = en_sh_q & ~{sup3, sup2, sup1, 1'b0};
      cur       = dig_sh_q[{idx_q, 2'b00} +: 4];
      show      = slot_q >= SLOT_BLANK && vis[idx_q];
      an_d      = show ? ~(4'b0001 << idx_q) : ANODE_OFF;
      seg_d     = show ? glyph : SEG_OFF;
      dp_d      = show ? ~dp_sh_q[idx_q] : 1'b1;
   end

   always_ff @(posedge clk_fpga or negedge reset_n) begin
      if (!reset_n) begin
         slot_q   <= '0;
         idx_q    <= '0;
         dig_sh_q <= '0;
         dp_sh_q  <= '0;
         en_sh_q  <= '0;
         lz_sh_q  <= 1'b0;
         seg_q    <= SEG_OFF;
         dp_q     <= 1'b1;
         an_q     <= ANODE_OFF;
      end else begin
         slot_q   <= slot_d;
         idx_q    <= idx_d;
         dig_sh_q <= dig_sh_d;
         dp_sh_q  <= dp_sh_d;
         en_sh_q  <= en_sh_d;
         lz_sh_q  <= lz_sh_d;
         seg_q    <= seg_d;
         dp_q     <= dp_d;
         an_q     <= an_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign anode_sel  = an_q;
   assign frame_tick = snap;
endmodule
